// File: rtl/exp3_pkg.sv
// Shared types and sizing for the exp3 datapath sweep controller.
// Vector i drives {a,b,c} = i and its {y,x} pair lives at bits [2i+1:2i].
package exp3_pkg;

  localparam int NUM_VEC = 8;
  localparam int RES_W   = 16;
  localparam int CNT_W   = 4;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  function automatic logic [1:0] get_pair(input logic [RES_W-1:0] v,
                                          input logic [IDX_W-1:0] i);
    return v[{i, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/exp3_settle_timer.sv
// Settle delay counter: counts while enabled and flags the last settle cycle.
// Clear takes priority so the count restarts from zero on every new vector.
module exp3_settle_timer
  import exp3_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/exp3_sweep_ctrl.sv
// Sweeps all 8 {a,b,c} vectors through the exp3 datapath, samples {y,x}
// after a settle delay and compares each pair against a latched table.
module exp3_sweep_ctrl
  import exp3_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [RES_W-1:0] exp_table,
  input  logic             x,
  input  logic             y,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic [RES_W-1:0] result,
  output logic [CNT_W-1:0] err_cnt,
  output logic             pass
);

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] abc_q;
  logic [RES_W-1:0] exp_q;
  logic [RES_W-1:0] result_q;
  logic [CNT_W-1:0] err_q;
  logic             busy_q, done_q, valid_q, pass_q;
  logic             settle_exp;

  // Timer is held cleared outside SETTLE, so each vector starts from zero.
  exp3_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (state_q != ST_SETTLE),
    .en_i    (state_q == ST_SETTLE),
    .expire_o(settle_exp)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      abc_q    <= '0;
      exp_q    <= '0;
      result_q <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_q  <= ST_SETTLE;
            idx_q    <= '0;
            abc_q    <= '0;
            exp_q    <= exp_table;
            result_q <= '0;
            err_q    <= '0;
            valid_q  <= 1'b0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        ST_SETTLE, ST_SAMPLE: begin
          if (abort) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            abc_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            pass_q  <= 1'b0;
          end else if (state_q == ST_SETTLE) begin
            if (settle_exp) state_q <= ST_SAMPLE;
          end else begin
            result_q[{idx_q, 1'b0} +: 2] <= {y, x};
            if ({y, x} != get_pair(exp_q, idx_q)) err_q <= err_q + CNT_W'(1);
            if (idx_q == IDX_W'(NUM_VEC - 1)) begin
              state_q <= ST_DONE;
              abc_q   <= '0;
            end else begin
              state_q <= ST_SETTLE;
              idx_q   <= idx_q + IDX_W'(1);
              abc_q   <= idx_q + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          // Abort is deliberately not looked at here: a finished sweep completes.
          state_q <= ST_IDLE;
          idx_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          valid_q <= 1'b1;
          pass_q  <= (err_q == '0);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign {a, b, c} = abc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign valid     = valid_q;
  assign result    = result_q;
  assign err_cnt   = err_q;
  assign pass      = pass_q;

endmodule

// File: doc/exp3_sweep_ctrl.md
EXP3_SWEEP_CTRL -- requirements
Module: exp3_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, legal range 1..15: cycles each input vector is held before sampling.
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a full 8-vector sweep, sampled in IDLE only.
REQ-005 SHALL have port abort  input  1  terminate the sweep in progress.
REQ-006 SHALL have port exp_table  input  16  expected {y,x} per vector, bits [2i+1:2i] for vector i, captured at start.
REQ-007 SHALL have port x, y  input  1 each  outputs of the exp3 datapath under control.
REQ-008 SHALL have port a, b, c  output  1 each  datapath inputs, {a,b,c} = vector index i (a = MSB).
REQ-009 SHALL have port busy  output  1  high in every state other than IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse on sweep completion.
REQ-011 SHALL have port valid  output  1  result, err_cnt and pass hold a completed sweep.
REQ-012 SHALL have port result  output  16  captured {y,x} per vector, same packing as exp_table.
REQ-013 SHALL have port err_cnt  output  4  number of vectors with result != exp_table (0..8).
REQ-014 SHALL have port pass  output  1  valid and err_cnt == 0.

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE.
REQ-016 IDLE: start=1 and abort=0 -> SETTLE next cycle; idx=0; settle counter=0; exp_table latched; result, err_cnt, valid cleared.
REQ-017 SETTLE: {a,b,c}=idx held stable; after SETTLE_CYCLES cycles in SETTLE -> SAMPLE.
REQ-018 SAMPLE (one cycle): result[2*idx+1:2*idx] <= {y,x}; err_cnt increments if {y,x} != latched expected pair.
REQ-019 SAMPLE: idx==7 -> DONE; otherwise idx+1 -> SETTLE, counter cleared. idx SHALL NOT wrap.
REQ-020 DONE (one cycle): done=1, valid=1 -> IDLE. valid, result and err_cnt SHALL hold until the next accepted start or reset.
REQ-021 Latency: done asserts exactly 8*(SETTLE_CYCLES+1)+1 cycles after the start-accept edge (25 for the default).
REQ-022 start SHALL be ignored while busy=1. Restart SHALL require a fresh start in IDLE.
REQ-023 abort in SETTLE or SAMPLE -> IDLE next cycle: no done, valid=0, {a,b,c}=000.
REQ-024 abort in DONE SHALL be ignored; the sweep completes.
REQ-025 start and abort asserted together in IDLE: abort wins and the sweep does not start.
REQ-026 {a,b,c}=000 SHALL hold in IDLE and DONE.

Reset
REQ-027 reset=1 at any edge, including mid-sweep, SHALL force IDLE next cycle with a=b=c=0, busy=0, done=0, valid=0, result=0, err_cnt=0, pass=0, idx=0, and settle counter=0.
REQ-028 reset SHALL take priority over start and abort.

Structure
REQ-029 A shared package exp3_pkg SHALL hold the state enum, NUM_VEC=8, RES_W=16, and the CNT_W=4 width constant.
REQ-030 The settle delay SHALL be one sub-module, exp3_settle_timer (load/clear, count, expire flag). All other logic SHALL stay in exp3_sweep_ctrl.

Verification
Bench model: x = a^b^c and y = majority(a,b,c). The correct table is 16'hE994.
REQ-031 Nominal sweep: exp_table=16'hE994, start pulse -> done at +25 cycles, result=16'hE994, err_cnt=0, pass=1.
REQ-032 Mismatch: exp_table=16'hE990 -> result=16'hE994, err_cnt=1, pass=0, valid=1.
REQ-033 Abort: abort at cycle 10 after start -> busy=0 next cycle, no done pulse, valid=0, abc=000.
REQ-034 Start during busy: a second start at cycle 5 -> no effect; single done at +25 cycles.
REQ-035 Reset mid-sweep: reset at cycle 12 -> all outputs zero next cycle; a new start then gives result=16'hE994 after 25 cycles.
REQ-036 Stability and timing: with SETTLE_CYCLES=1, abc steps 000..111 every 2 cycles and done comes at +17 cycles. A checker SHALL assert abc never changes in SETTLE.
